// File: rtl/video_pkg.sv
// video_pkg: shared palette defaults, attribute field positions and colour scaling.
package video_pkg;
  localparam int ATTR_FG_LSB = 0;
  localparam int ATTR_FG_W = 4;
  localparam int ATTR_BG_LSB = 4;
  localparam int ATTR_BG_W = 3;
  localparam int ATTR_MSB = 7;
  localparam logic [23:0] DEFAULT_PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };
  // Keeps the top color_w bits of each channel, packed into the low 3*color_w bits.
  function automatic logic [23:0] scale_color(input logic [23:0] rgb24, input int color_w);
    logic [23:0] r, g, b;
    r = {16'd0, rgb24[23:16]} >> (8 - color_w);
    g = {16'd0, rgb24[15:8]} >> (8 - color_w);
    b = {16'd0, rgb24[7:0]} >> (8 - color_w);
    return (r << (2 * color_w)) | (g << color_w) | b;
  endfunction
endpackage

// File: rtl/palette_regfile.sv
// palette_regfile: 16-entry colour table, one sync write port, one registered read port.
module palette_regfile
  import video_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   we_i,
  input  logic [3:0]             waddr_i,
  input  logic [3*COLOR_W-1:0]   wdata_i,
  input  logic                   re_i,
  input  logic [3:0]             raddr_i,
  output logic [3*COLOR_W-1:0]   rdata_o
);
  logic [3*COLOR_W-1:0] r_mem [16];
  logic [3*COLOR_W-1:0] w_def [16];
  logic [3*COLOR_W-1:0] r_rdata;
  for (genvar k = 0; k < 16; k++) begin : g_def
    assign w_def[k] = (3*COLOR_W)'(scale_color(DEFAULT_PALETTE[k], COLOR_W));
  end
  // Read samples the pre-write contents, so a same-edge write is seen one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= w_def[i];
      r_rdata <= '0;
    end else begin
      if (we_i) r_mem[waddr_i] <= wdata_i;
      if (re_i) r_rdata <= r_mem[raddr_i];
    end
  end
  assign rdata_o = r_rdata;
endmodule

// File: rtl/attribute_palette.sv
// attribute_palette: text-mode attribute + glyph bit to RGB via a writable palette with frame-timed blink.
module attribute_palette
  import video_pkg::*;
#(
  parameter int COLOR_W = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pal_we_i,
  input  logic [3:0]           pal_addr_i,
  input  logic [3*COLOR_W-1:0] pal_wdata_i,
  input  logic                 frame_start_i,
  input  logic                 blink_mode_i,
  input  logic                 in_valid_i,
  input  logic [7:0]           attribute_i,
  input  logic                 pixel_on_i,
  output logic                 out_valid_o,
  output logic [3*COLOR_W-1:0] rgb_o,
  output logic                 blink_phase_o
);
  localparam int CNT_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_phase;
  logic r_s1_valid, r_s1_pix, r_s1_mode, r_s1_phase, r_out_valid;
  logic [7:0] r_s1_attr;
  logic [3:0] w_fg, w_bg, w_idx;
  logic w_hide, w_wrap;
  assign w_wrap = r_cnt == CNT_LAST;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_phase <= 1'b0;
    end else if (frame_start_i) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_phase <= r_phase ^ w_wrap;
    end
  end
  // Stage 1 latches the pre-edge blink phase so a pixel's phase is fixed on entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
      r_s1_attr <= '0;
      r_s1_pix <= 1'b0;
      r_s1_mode <= 1'b0;
      r_s1_phase <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid_i;
      r_s1_attr <= attribute_i;
      r_s1_pix <= pixel_on_i;
      r_s1_mode <= blink_mode_i;
      r_s1_phase <= r_phase;
      r_out_valid <= r_s1_valid;
    end
  end
  always_comb begin
    w_fg = r_s1_attr[ATTR_FG_LSB +: ATTR_FG_W];
    w_bg = r_s1_mode ? {1'b0, r_s1_attr[ATTR_BG_LSB +: ATTR_BG_W]} : r_s1_attr[ATTR_MSB -: 4];
    w_hide = r_s1_mode & r_s1_attr[ATTR_MSB] & r_s1_phase;
    w_idx = (r_s1_pix & ~w_hide) ? w_fg : w_bg;
  end
  palette_regfile #(.COLOR_W(COLOR_W)) u_pal (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (pal_we_i),
    .waddr_i (pal_addr_i),
    .wdata_i (pal_wdata_i),
    .re_i    (r_s1_valid),
    .raddr_i (w_idx),
    .rdata_o (rgb_o)
  );
  assign out_valid_o = r_out_valid;
  assign blink_phase_o = r_phase;
endmodule

// File: tb/tb_attribute_palette.sv
// tb_attribute_palette: directed stimulus on an 8-bit/2-frame build and a 4-bit/16-frame build, checked against a behavioural model.
module tb_attribute_palette;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, pal_we = 1'b0, frame_start = 1'b0, blink_mode = 1'b1, in_valid = 1'b0, pixel_on = 1'b0;
  logic [3:0] pal_addr = '0;
  logic [23:0] wd = '0;
  logic [11:0] wd4 = '0;
  logic [7:0] attr = '0;
  logic ov8, ov4, ph8, ph4;
  logic [23:0] rgb8;
  logic [11:0] rgb4;
  int checks = 0, failures = 0;
  attribute_palette #(.COLOR_W(8), .BLINK_FRAMES(2)) u_dut (
    .clk_i(clk), .reset_i(reset), .pal_we_i(pal_we), .pal_addr_i(pal_addr), .pal_wdata_i(wd),
    .frame_start_i(frame_start), .blink_mode_i(blink_mode), .in_valid_i(in_valid),
    .attribute_i(attr), .pixel_on_i(pixel_on), .out_valid_o(ov8), .rgb_o(rgb8), .blink_phase_o(ph8)
  );
  attribute_palette #(.COLOR_W(4), .BLINK_FRAMES(16)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .pal_we_i(pal_we), .pal_addr_i(pal_addr), .pal_wdata_i(wd4),
    .frame_start_i(frame_start), .blink_mode_i(blink_mode), .in_valid_i(in_valid),
    .attribute_i(attr), .pixel_on_i(pixel_on), .out_valid_o(ov4), .rgb_o(rgb4), .blink_phase_o(ph4)
  );
  logic [23:0] vga [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA, 24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF, 24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };
  logic [23:0] pal8 [16];
  logic [11:0] pal4 [16];
  int cnt8 = 0, cnt4 = 0;
  bit mph8 = 0, mph4 = 0, s1v = 0, s1p = 0, s1m = 0, s1ph8 = 0, s1ph4 = 0, mv = 0, armed = 0;
  logic [7:0] s1a = '0;
  logic [23:0] m8 = '0;
  logic [11:0] m4 = '0;
  function automatic int pick(input logic [7:0] a, input bit p, input bit m, input bit ph);
    int v;
    v = int'(a);
    if (p && !(m && a[7] && ph)) return v % 16;
    return m ? (v / 16) % 8 : v / 16;
  endfunction
  function automatic logic [11:0] to4(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pal8[i] = vga[i];
        pal4[i] = to4(vga[i]);
      end
      cnt8 = 0; cnt4 = 0; mph8 = 0; mph4 = 0; s1v = 0; mv = 0; m8 = '0; m4 = '0; armed = 1;
    end else begin
      if (s1v) begin
        m8 = pal8[pick(s1a, s1p, s1m, s1ph8)];
        m4 = pal4[pick(s1a, s1p, s1m, s1ph4)];
      end
      mv = s1v;
      s1v = in_valid; s1a = attr; s1p = pixel_on; s1m = blink_mode; s1ph8 = mph8; s1ph4 = mph4;
      if (pal_we) begin
        pal8[pal_addr] = wd;
        pal4[pal_addr] = wd4;
      end
      if (frame_start) begin
        cnt8 = cnt8 + 1;
        if (cnt8 == 2) begin cnt8 = 0; mph8 = !mph8; end
        cnt4 = cnt4 + 1;
        if (cnt4 == 16) begin cnt4 = 0; mph4 = !mph4; end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (armed) begin
      chk("model_valid8", 32'(ov8), 32'(mv));
      chk("model_rgb8", 32'(rgb8), 32'(m8));
      chk("model_phase8", 32'(ph8), 32'(mph8));
      chk("model_valid4", 32'(ov4), 32'(mv));
      chk("model_rgb4", 32'(rgb4), 32'(m4));
      chk("model_phase4", 32'(ph4), 32'(mph4));
    end
  end
  task automatic cyc(input bit v, input logic [7:0] a, input bit p);
    @(negedge clk);
    in_valid = v; attr = a; pixel_on = p; pal_we = 0; frame_start = 0; reset = 0;
  endtask
  initial begin
    cyc(0, 0, 0); reset = 1;
    cyc(0, 0, 0);
    chk("rst_valid", 32'(ov8), 0);
    chk("rst_rgb", 32'(rgb8), 0);
    chk("rst_phase", 32'(ph8), 0);
    cyc(1, 8'h1F, 1); cyc(1, 8'h1F, 0); cyc(1, 8'h0E, 1);
    chk("def_fg", 32'(rgb8), 32'h FFFFFF);
    chk("def_valid", 32'(ov8), 1);
    cyc(0, 0, 0);
    chk("def_bg", 32'(rgb8), 32'h0000AA);
    cyc(0, 0, 0);
    chk("def_fg_e", 32'(rgb8), 32'hFFFF55);
    chk("w4_fg_e", 32'(rgb4), 32'hFF5);
    cyc(0, 0, 0); pal_we = 1; pal_addr = 4; wd = 24'h123456; wd4 = 12'h135;
    cyc(1, 8'h04, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("pal_write", 32'(rgb8), 32'h123456);
    chk("pal_write4", 32'(rgb4), 32'h135);
    cyc(1, 8'h02, 1);
    cyc(0, 0, 0); pal_we = 1; pal_addr = 2; wd = 24'h112233; wd4 = 12'h123;
    cyc(0, 0, 0);
    chk("hazard_old", 32'(rgb8), 32'h00AA00);
    cyc(1, 8'h02, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("hazard_new", 32'(rgb8), 32'h112233);
    cyc(1, 8'h9E, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("blink_ph0", 32'(rgb8), 32'hFFFF55);
    cyc(0, 0, 0); frame_start = 1;
    cyc(0, 0, 0); frame_start = 1;
    cyc(0, 0, 0);
    chk("phase_toggle", 32'(ph8), 1);
    chk("phase_slow", 32'(ph4), 0);
    cyc(1, 8'h9E, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("blink_ph1", 32'(rgb8), 32'h0000AA);
    blink_mode = 0;
    cyc(1, 8'hC0, 0); cyc(1, 8'h8E, 1); cyc(0, 0, 0);
    chk("intensity_bg", 32'(rgb8), 32'hFF5555);
    cyc(0, 0, 0);
    chk("intensity_fg", 32'(rgb8), 32'hFFFF55);
    blink_mode = 1;
    cyc(0, 0, 0); frame_start = 1;
    cyc(0, 0, 0); frame_start = 1;
    cyc(0, 0, 0);
    chk("phase_back", 32'(ph8), 0);
    cyc(1, 8'h9E, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("blink_ph0_again", 32'(rgb8), 32'hFFFF55);
    cyc(0, 0, 0); frame_start = 1;
    cyc(1, 8'h9E, 1); frame_start = 1;
    cyc(1, 8'h9E, 1);
    cyc(0, 0, 0);
    chk("phase_at_entry", 32'(rgb8), 32'hFFFF55);
    cyc(0, 0, 0);
    chk("phase_after", 32'(rgb8), 32'h0000AA);
    cyc(1, 8'h01, 1); cyc(0, 0, 0); cyc(1, 8'h02, 1);
    chk("bubble_v1", 32'(ov8), 1);
    cyc(0, 0, 0);
    chk("bubble_v0", 32'(ov8), 0);
    chk("bubble_hold", 32'(rgb8), 32'h0000AA);
    cyc(0, 0, 0);
    chk("bubble_v1b", 32'(ov8), 1);
    cyc(0, 0, 0);
    chk("bubble_v0b", 32'(ov8), 0);
    cyc(0, 0, 0); pal_we = 1; pal_addr = 0; wd = 24'hABCDEF; wd4 = 12'hACE;
    cyc(1, 8'h04, 1); cyc(1, 8'h00, 1); reset = 1;
    cyc(0, 0, 0);
    chk("midrst_valid", 32'(ov8), 0);
    chk("midrst_rgb", 32'(rgb8), 0);
    chk("midrst_phase", 32'(ph8), 0);
    cyc(1, 8'h04, 1); cyc(1, 8'h00, 1); cyc(0, 0, 0);
    chk("midrst_pal4", 32'(rgb8), 32'hAA0000);
    cyc(0, 0, 0);
    chk("midrst_pal0", 32'(rgb8), 32'h000000);
    chk("midrst_pal0_v", 32'(ov8), 1);
    cyc(0, 0, 0); cyc(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/attribute_palette.md
# attribute_palette

Programmable text-mode colour stage for the video pipeline. Takes an 8-bit character attribute plus the glyph pixel bit from the font stage and produces the final RGB pixel. Colours come from a 16-entry writable palette (reset to the standard VGA palette). Blink is frame-timed, and a mode bit selects blink or 16-colour background. Sits between the glyph/font fetch and the video timing/DAC output.

## Interface
- COLOR_W, 8, bits per channel, legal range 4..8; output is {R,G,B}, 3*COLOR_W wide.
- BLINK_FRAMES, 16, frames per blink half-period, >= 1.
- PIPE_LAT, 2, fixed pipeline latency; informational only, not overridable.

- clk_i  input  1  pixel clock; only clock.
- reset_i  input  1  synchronous, active-high reset.
- pal_we_i  input  1  palette write strobe.
- pal_addr_i  input  4  palette entry index.
- pal_wdata_i  input  3*COLOR_W  new {R,G,B} for the entry.
- frame_start_i  input  1  one-cycle pulse at start of each frame.
- blink_mode_i  input  1  1: attr[7] = blink; 0: attr[7] = background intensity bit.
- in_valid_i  input  1  attribute/pixel valid this cycle.
- attribute_i  input  8  [3:0] fg index, [6:4] bg index, [7] blink/intensity.
- pixel_on_i  input  1  glyph bit: 1 selects foreground.
- out_valid_o  output  1  rgb_o valid.
- rgb_o  output  3*COLOR_W  final pixel colour.
- blink_phase_o  output  1  current blink phase; 1 = blinking text hidden.

## Operation
- Palette reset contents:
  - VGA 16 colours: 000000, 0000AA, 00AA00, 00AAAA, AA0000, AA00AA, AA5500, AAAAAA, 555555, 5555FF, 55FF55, 55FFFF, FF5555, FF55FF, FFFF55, FFFFFF.
  - Each 8-bit channel is truncated to its top COLOR_W bits.
- Index selection:
  - Foreground index is attr[3:0].
  - Background index is {1'b0, attr[6:4]} when blink_mode_i = 1.
  - Background index is attr[7:4] when blink_mode_i = 0.
- Blink:
  - Applies only when blink_mode_i = 1, attr[7] = 1 and blink_phase = 1.
  - Under those conditions the pixel uses the background colour regardless of pixel_on_i.
- Output colour: rgb_o = palette[pixel_on ? fg_idx : bg_idx] after the blink override.
- Blink counter:
  - Counts frame_start_i pulses from 0 to BLINK_FRAMES-1.
  - On the pulse that arrives at count BLINK_FRAMES-1, the counter wraps to 0 and blink_phase toggles.
  - With BLINK_FRAMES = 1, phase toggles every frame.
- Palette writes: when pal_we_i = 1, pal_wdata_i is written to entry pal_addr_i at the clock edge. No handshake; writes are always accepted.
- No backpressure; the block consumes one input per cycle.

## Timing
- Latency is 2 cycles: the input at edge N appears on out_valid_o/rgb_o after edge N+2. Bubbles propagate, and out_valid_o follows in_valid_i delayed by 2 cycles.
- Stage 1 registers attribute, pixel_on, blink_mode and valid. It also samples blink_phase, so one pixel's phase is fixed at stage-1 entry.
- Stage 2 does the palette read and colour mux, then registers rgb_o.
- Palette write in the same cycle as a stage-2 read of the same entry: the read returns the OLD value. The new value is visible from the next cycle.
- frame_start_i toggles blink_phase_o at that clock edge. Pixels already in stage 2 are unaffected.
- rgb_o holds its last value when out_valid_o = 0.
- Reset (any cycle, including mid-stream), effective on the next edge:
  - out_valid_o = 0, rgb_o = 0, blink_phase_o = 0.
  - Blink counter = 0.
  - All palette entries restored to defaults.
  - Pipeline contents discarded.

## Structure
- video_pkg holds:
  - The DEFAULT_PALETTE constant: 16 x 24-bit entries.
  - The attribute field-position localparams.
  - A scale_color(rgb24, COLOR_W) function.
- Sub-module palette_regfile: 16 entries, 1 synchronous write port, 1 registered read port, synchronous reset to package defaults.
- The blink counter and the pipeline stay in the top module.

## Test plan
- Reset defaults: reset, then stream attr 0x1F with pixel_on = 1, then 0 -> rgb_o FFFFFF, then 0000AA, each 2 cycles after input, out_valid_o aligned.
- Palette write: write entry 4 = 123456, next cycle stream attr 0x04 with pixel_on = 1 -> 123456. Same-cycle write/read of entry 2 -> old 00AA00.
- Blink mode:
  - BLINK_FRAMES = 2, blink_mode_i = 1, attr 0x9E, pixel_on = 1.
  - Phase 0 -> FFFF55.
  - After 2 frame_start pulses, phase 1 -> 0000AA.
  - After 2 more pulses -> FFFF55.
- Intensity mode: blink_mode_i = 0, attr 0xC0, pixel_on = 0 -> FF5555. blink_phase ignored in this mode.
- Bubbles and reset: alternate in_valid_i 1/0 -> out_valid_o pattern delayed 2 cycles. Assert reset mid-stream after palette writes -> out_valid_o = 0 next cycle; palette reads back defaults; blink_phase_o = 0.
- COLOR_W = 4 build: attr 0x0E with pixel_on = 1 -> rgb_o 12'hFF5.
